fft4_q15: RTL and testbench
===========================

Name: fft4_q15

Overview:
- Fully pipelined 4-point complex DFT (radix-2 DIT, two butterfly stages) on Q1.15 samples.
- Accepts one 4-sample vector per clock on parallel ports and produces all 4 frequency bins in parallel.
- Scales by 1/4 (1/2 per stage), so outputs never overflow.
- Sits in the datapath as a small transform kernel with no handshake; it runs every cycle.

Parameters:
- WIDTH, 16, sample width per real/imag component (signed Q1.(WIDTH-1)).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- x0_real, x0_imag  in  WIDTH  time sample 0, signed Q1.15.
- x1_real, x1_imag  in  WIDTH  time sample 1.
- x2_real, x2_imag  in  WIDTH  time sample 2.
- x3_real, x3_imag  in  WIDTH  time sample 3.
- X0_real, X0_imag  out  WIDTH  bin 0 (DC), registered.
- X1_real, X1_imag  out  WIDTH  bin 1, registered.
- X2_real, X2_imag  out  WIDTH  bin 2, registered.
- X3_real, X3_imag  out  WIDTH  bin 3, registered.

Behaviour:
- Transfer function: Xk = (1/4) * sum over n of xn * W^(nk), with W = exp(-j*2*pi/4).
  - X0 = (x0+x1+x2+x3)/4
  - X1 = ((x0-x2) - j(x1-x3))/4
  - X2 = ((x0+x2)-(x1+x3))/4
  - X3 = ((x0-x2) + j(x1-x3))/4
- Stage 1 (registered), all complex:
  - A = (x0+x2)>>>1, B = (x0-x2)>>>1, C = (x1+x3)>>>1, D = (x1-x3)>>>1.
  - Sums are formed at WIDTH+1 bits, then arithmetic-shifted right by 1 back to WIDTH.
- Stage 2 (registered outputs):
  - X0 = (A+C)>>>1, X2 = (A-C)>>>1.
  - X1 = (B_re + D_im, B_im - D_re)>>>1.
  - X3 = (B_re - D_im, B_im + D_re)>>>1.
  - Again WIDTH+1-bit intermediates, shifted to WIDTH.
- Rounding: truncation toward minus infinity (plain arithmetic shift). No rounding constant, no saturation; overflow is impossible by construction.
- Latency: exactly 2 clocks. A vector sampled at edge N appears on the outputs after edge N+1 and stays until edge N+2 updates them.
- Throughput: one vector per clock. Inputs are sampled every edge; there is no valid or enable signal.
- Reset: while rst is high at an edge, both stage registers and all 16 output components load 0.
  - Reset asserted mid-stream discards in-flight data.
  - After release, the first real result appears 2 edges after the first sampled vector.
- Inputs held constant: outputs are constant from the 2nd edge onward.

Decomposition:
- Shared package: WIDTH constant and a complex typedef {signed re, im} of WIDTH bits.
- Natural sub-module fft4_bfly: combinational radix-2 halving butterfly (inputs p, q; outputs (p+q)>>>1 and (p-q)>>>1).
  - Stage 1 uses four instances (A and B on the real and imaginary parts of x0/x2; C and D on x1/x3).
  - Stage 2 uses four instances, with the -j / +j twiddle done by swapping re/im and negating at the inputs.

Test Plan:
- Reset held, then x1_real = x3_real = 0x4000, all else 0 -> 2 clocks later: X0 = (0x2000, 0), X2 = (0xE000, 0), X1 = X3 = (0, 0).
- Impulse x0_real = 0x4000, all else 0 -> all four bins = (0x1000, 0).
- All four real inputs 0x8000, imag 0 -> X0 = (0x8000, 0), X1 = X2 = X3 = (0, 0); no wrap.
- x1_real = 0x4000 only -> X0 = (0x1000, 0), X1 = (0, 0xF000), X2 = (0xF000, 0), X3 = (0, 0x1000).
- Truncation: x0_real = 0x0001 -> all outputs 0; x0_real = 0xFFFF -> all real outputs 0xFFFF.
- Streaming: a different vector every clock -> each result matches its own vector exactly 2 clocks later. Assert rst for one cycle mid-stream -> outputs 0 on the next edge, resuming 2 edges after release.

Source files
------------

// File: rtl/fft4_q15_pkg.sv
// Shared definitions for the 4-point Q1.15 DFT kernel.
package fft4_q15_pkg;

    // Default width of one real or imaginary component.
    localparam int DATA_WIDTH = 16;

    // One complex sample. Both parts are signed Q1.(DATA_WIDTH-1).
    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft4_bfly.sv
// Combinational radix-2 halving butterfly on one real component.
// sum = (p+q)>>>1, diff = (p-q)>>>1. The intermediates are one bit
// wider than the inputs, so the halved result always fits back in W bits.
module fft4_bfly
    import fft4_q15_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic signed [W-1:0] p,
    input  logic signed [W-1:0] q,
    output logic signed [W-1:0] sum,
    output logic signed [W-1:0] diff
);

    logic signed [W:0] sum_w;
    logic signed [W:0] diff_w;

    assign sum_w  = {p[W-1], p} + {q[W-1], q};
    assign diff_w = {p[W-1], p} - {q[W-1], q};

    // Arithmetic shift truncates toward minus infinity; no rounding term.
    assign sum  = W'(sum_w >>> 1);
    assign diff = W'(diff_w >>> 1);

endmodule

// File: rtl/fft4_q15.sv
// Fully pipelined 4-point complex DFT, radix-2 DIT, two halving stages.
// One vector in and four bins out per clock; latency is two clocks.
// The stage registers are cplx_t, so WIDTH must stay equal to DATA_WIDTH.
module fft4_q15
    import fft4_q15_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x0_real,
    input  logic [WIDTH-1:0] x0_imag,
    input  logic [WIDTH-1:0] x1_real,
    input  logic [WIDTH-1:0] x1_imag,
    input  logic [WIDTH-1:0] x2_real,
    input  logic [WIDTH-1:0] x2_imag,
    input  logic [WIDTH-1:0] x3_real,
    input  logic [WIDTH-1:0] x3_imag,
    output logic [WIDTH-1:0] X0_real,
    output logic [WIDTH-1:0] X0_imag,
    output logic [WIDTH-1:0] X1_real,
    output logic [WIDTH-1:0] X1_imag,
    output logic [WIDTH-1:0] X2_real,
    output logic [WIDTH-1:0] X2_imag,
    output logic [WIDTH-1:0] X3_real,
    output logic [WIDTH-1:0] X3_imag
);

    // ---------------- Stage 1: pairs (x0,x2) and (x1,x3) ----------------
    logic [WIDTH-1:0] a_re_d, a_im_d, b_re_d, b_im_d;
    logic [WIDTH-1:0] c_re_d, c_im_d, d_re_d, d_im_d;
    cplx_t            a_q, b_q, c_q, d_q;

    fft4_bfly #(.W(WIDTH)) u_s1_ab_re (.p(x0_real), .q(x2_real), .sum(a_re_d), .diff(b_re_d));
    fft4_bfly #(.W(WIDTH)) u_s1_ab_im (.p(x0_imag), .q(x2_imag), .sum(a_im_d), .diff(b_im_d));
    fft4_bfly #(.W(WIDTH)) u_s1_cd_re (.p(x1_real), .q(x3_real), .sum(c_re_d), .diff(d_re_d));
    fft4_bfly #(.W(WIDTH)) u_s1_cd_im (.p(x1_imag), .q(x3_imag), .sum(c_im_d), .diff(d_im_d));

    // Stage 1 register: capture A, B, C, D; reset discards in-flight data.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch and is only seen at an edge.
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            d_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            a_q <= '{re: a_re_d, im: a_im_d};
            b_q <= '{re: b_re_d, im: b_im_d};
            c_q <= '{re: c_re_d, im: c_im_d};
            d_q <= '{re: d_re_d, im: d_im_d};
        end
    end

    // ---------------- Stage 2: combine with -j / +j twiddle ----------------
    // X1 = B - jD and X3 = B + jD. Multiplying D by -j swaps its parts and
    // negates one, so pairing B_re with D_im and B_im with D_re yields both
    // bins from the sum/diff outputs of two butterflies.
    logic [WIDTH-1:0] y0_re_d, y0_im_d, y1_re_d, y1_im_d;
    logic [WIDTH-1:0] y2_re_d, y2_im_d, y3_re_d, y3_im_d;

    fft4_bfly #(.W(WIDTH)) u_s2_ac_re (.p(a_q.re), .q(c_q.re), .sum(y0_re_d), .diff(y2_re_d));
    fft4_bfly #(.W(WIDTH)) u_s2_ac_im (.p(a_q.im), .q(c_q.im), .sum(y0_im_d), .diff(y2_im_d));
    fft4_bfly #(.W(WIDTH)) u_s2_bd_re (.p(b_q.re), .q(d_q.im), .sum(y1_re_d), .diff(y3_re_d));
    fft4_bfly #(.W(WIDTH)) u_s2_bd_im (.p(b_q.im), .q(d_q.re), .sum(y3_im_d), .diff(y1_im_d));

    // Output register: publish all four bins together.
    always_ff @(posedge clk) begin
        if (rst) begin
            X0_real <= '0;
            X0_imag <= '0;
            X1_real <= '0;
            X1_imag <= '0;
            X2_real <= '0;
            X2_imag <= '0;
            X3_real <= '0;
            X3_imag <= '0;
        end else begin
            X0_real <= y0_re_d;
            X0_imag <= y0_im_d;
            X1_real <= y1_re_d;
            X1_imag <= y1_im_d;
            X2_real <= y2_re_d;
            X2_imag <= y2_im_d;
            X3_real <= y3_re_d;
            X3_imag <= y3_im_d;
        end
    end

endmodule

// File: tb/tb_fft4_q15.sv
// Directed, table-driven bench for fft4_q15. Inputs change on the falling
// edge; outputs are read on the falling edge, half a clock after they update.
module tb_fft4_q15;

    localparam int W = 16;
    localparam int NV = 11;

    typedef struct packed {
        logic [3:0][W-1:0] xr;
        logic [3:0][W-1:0] xi;
        logic [3:0][W-1:0] yr;
        logic [3:0][W-1:0] yi;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vec_t cur;
    vec_t tv [NV];

    logic [W-1:0] x0_real, x0_imag, x1_real, x1_imag;
    logic [W-1:0] x2_real, x2_imag, x3_real, x3_imag;
    logic [W-1:0] X0_real, X0_imag, X1_real, X1_imag;
    logic [W-1:0] X2_real, X2_imag, X3_real, X3_imag;
    logic [3:0][W-1:0] out_r, out_i;

    int checks = 0;
    int errors = 0;

    assign x0_real = cur.xr[0];
    assign x0_imag = cur.xi[0];
    assign x1_real = cur.xr[1];
    assign x1_imag = cur.xi[1];
    assign x2_real = cur.xr[2];
    assign x2_imag = cur.xi[2];
    assign x3_real = cur.xr[3];
    assign x3_imag = cur.xi[3];
    assign out_r   = {X3_real, X2_real, X1_real, X0_real};
    assign out_i   = {X3_imag, X2_imag, X1_imag, X0_imag};

    fft4_q15 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .x0_real (x0_real),
        .x0_imag (x0_imag),
        .x1_real (x1_real),
        .x1_imag (x1_imag),
        .x2_real (x2_real),
        .x2_imag (x2_imag),
        .x3_real (x3_real),
        .x3_imag (x3_imag),
        .X0_real (X0_real),
        .X0_imag (X0_imag),
        .X1_real (X1_real),
        .X1_imag (X1_imag),
        .X2_real (X2_real),
        .X2_imag (X2_imag),
        .X3_real (X3_real),
        .X3_imag (X3_imag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got re=%h im=%h, expected re=%h im=%h",
                     name, got[2*W-1:W], got[W-1:0], exp[2*W-1:W], exp[W-1:0]);
        end
    endtask

    task automatic check_bins(input string tag, input logic [3:0][W-1:0] er, input logic [3:0][W-1:0] ei);
        for (int k = 0; k < 4; k++)
            check($sformatf("%s X%0d", tag, k), {out_r[k], out_i[k]}, {er[k], ei[k]});
    endtask

    initial begin
        // ---- hand-computed vectors ----
        for (int i = 0; i < NV; i++) tv[i] = '0;
        // x1 = x3 = 0.5 real
        tv[0].xr[1] = 16'h4000; tv[0].xr[3] = 16'h4000;
        tv[0].yr[0] = 16'h2000; tv[0].yr[2] = 16'hE000;
        // impulse at x0
        tv[1].xr[0] = 16'h4000;
        for (int k = 0; k < 4; k++) tv[1].yr[k] = 16'h1000;
        // all -1.0: largest magnitude, must not wrap
        for (int k = 0; k < 4; k++) tv[2].xr[k] = 16'h8000;
        tv[2].yr[0] = 16'h8000;
        // impulse at x1
        tv[3].xr[1] = 16'h4000;
        tv[3].yr[0] = 16'h1000; tv[3].yi[1] = 16'hF000;
        tv[3].yr[2] = 16'hF000; tv[3].yi[3] = 16'h1000;
        // +1 LSB truncates to zero everywhere
        tv[4].xr[0] = 16'h0001;
        // -1 LSB truncates toward minus infinity
        tv[5].xr[0] = 16'hFFFF;
        for (int k = 0; k < 4; k++) tv[5].yr[k] = 16'hFFFF;
        // impulse at x2
        tv[6].xr[2] = 16'h4000;
        tv[6].yr[0] = 16'h1000; tv[6].yr[1] = 16'hF000;
        tv[6].yr[2] = 16'h1000; tv[6].yr[3] = 16'hF000;
        // impulse at x3
        tv[7].xr[3] = 16'h4000;
        tv[7].yr[0] = 16'h1000; tv[7].yi[1] = 16'h1000;
        tv[7].yr[2] = 16'hF000; tv[7].yi[3] = 16'hF000;
        // imaginary impulse at x1
        tv[8].xi[1] = 16'h4000;
        tv[8].yi[0] = 16'h1000; tv[8].yr[1] = 16'h1000;
        tv[8].yi[2] = 16'hF000; tv[8].yr[3] = 16'hF000;
        // all max positive
        for (int k = 0; k < 4; k++) tv[9].xr[k] = 16'h7FFF;
        tv[9].yr[0] = 16'h7FFF;
        // x0 = 0.25, x1 = 0.25j
        tv[10].xr[0] = 16'h2000; tv[10].xi[1] = 16'h2000;
        tv[10].yr[0] = 16'h0800; tv[10].yi[0] = 16'h0800;
        tv[10].yr[1] = 16'h1000;
        tv[10].yr[2] = 16'h0800; tv[10].yi[2] = 16'hF800;

        // ---- reset held with a live vector on the inputs ----
        cur = tv[0];
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_bins("reset", '0, '0);

        // ---- first result lands two edges after release ----
        rst = 1'b0;
        @(negedge clk);
        check_bins("release+1", '0, '0);
        @(negedge clk);
        check_bins("vec0", tv[0].yr, tv[0].yi);

        // ---- table: each vector held for two edges ----
        for (int i = 1; i < NV; i++) begin
            cur = tv[i];
            @(negedge clk);
            @(negedge clk);
            check_bins($sformatf("vec%0d", i), tv[i].yr, tv[i].yi);
        end

        // ---- held inputs keep outputs constant ----
        @(negedge clk);
        check_bins("hold", tv[NV-1].yr, tv[NV-1].yi);

        // ---- streaming: a new vector every clock ----
        for (int k = 0; k < NV + 2; k++) begin
            if (k >= 2)
                check_bins($sformatf("stream%0d", k - 2), tv[k-2].yr, tv[k-2].yi);
            cur = (k < NV) ? tv[k] : vec_t'('0);
            @(negedge clk);
        end

        // ---- one-cycle reset mid-stream ----
        cur = tv[0];
        @(negedge clk);
        cur = tv[1];
        @(negedge clk);
        cur = tv[2];
        rst = 1'b1;
        @(negedge clk);
        check_bins("midreset", '0, '0);
        rst = 1'b0;
        cur = tv[3];
        @(negedge clk);
        check_bins("resume+1", '0, '0);
        cur = tv[4];
        @(negedge clk);
        check_bins("resume vec3", tv[3].yr, tv[3].yi);
        cur = tv[6];
        @(negedge clk);
        check_bins("resume vec4", tv[4].yr, tv[4].yi);
        @(negedge clk);
        check_bins("resume vec6", tv[6].yr, tv[6].yi);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
